// File: rtl/sort_quad_loader.sv
// rtl/sort_quad_loader.sv - groups a valid/ready byte stream into padded 4-slot frames for the merge sorter
// Optional frame/pad statistics counters enabled by SORT_LOADER_STATS_EN.
module sort_quad_loader #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [3:0]        out_pad_mask,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SORT_LOADER_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       pad_count
`endif
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] slot [4];
  logic              in_fire, out_fire, close;
  logic [1:0]        widx;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // In HOLD an accepted element always starts a new frame (it coincides with out_fire).
  assign widx     = (state_q == HOLD) ? 2'd0 : cnt;
  assign close    = in_last | (widx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (in_fire && close) state_d = HOLD;
      HOLD:    if (out_fire) state_d = (in_fire && close) ? HOLD : COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) in_ready = (state_q == COLLECT) | out_ready;
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 2'd0;
      out_pad_mask <= 4'b0000;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else if (in_fire) begin
      slot[widx] <= in_data;
      if (close) begin
        cnt <= 2'd0;
        for (int i = 0; i < 4; i++) begin
          out_pad_mask[i] <= (i > int'(widx));
          if (i > int'(widx)) slot[i] <= PAD_VALUE;
        end
      end else begin
        cnt          <= widx + 2'd1;
        out_pad_mask <= 4'b0000;
      end
    end else if (out_fire) begin
      cnt          <= 2'd0;
      out_pad_mask <= 4'b0000;
    end
  end

  assign out_a = slot[0];
  assign out_b = slot[1];
  assign out_c = slot[2];
  assign out_d = slot[3];

`ifdef SORT_LOADER_STATS_EN
  // Free-running counters; wrap at 16 bits by design.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= 16'd0;
      pad_count   <= 16'd0;
    end else if (out_fire) begin
      frame_count <= frame_count + 16'd1;
      if (out_pad_mask != 4'b0000) pad_count <= pad_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sort_quad_loader.sv
// tb/tb_sort_quad_loader.sv - scoreboard bench for sort_quad_loader with directed frames
module tb_sort_quad_loader;
  localparam logic [7:0] PAD = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic [3:0] out_pad_mask;
  logic       out_valid, out_ready;
`ifdef SORT_LOADER_STATS_EN
  logic [15:0] frame_count, pad_count;
`endif

  int checks = 0;
  int errors = 0;
  int cycles = 0;
  logic [35:0] exp_q [$];

  sort_quad_loader #(.DATA_W(8), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_pad_mask(out_pad_mask), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SORT_LOADER_STATS_EN
    , .frame_count(frame_count), .pad_count(pad_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, b, c, d, input logic [3:0] m);
    exp_q.push_back({a, b, c, d, m});
  endtask

  // Called at a negedge; returns at the negedge after the element is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    in_data = d; in_valid = 1'b1; in_last = l;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL send_timeout: element %h not accepted", d);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame: got %h expected none",
                 {out_a, out_b, out_c, out_d, out_pad_mask});
      end else begin
        check("frame", {28'd0, out_a, out_b, out_c, out_d, out_pad_mask}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int c0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    check("in_ready_in_reset", in_ready, 0);
    in_valid = 1'b1;
    #1 check("in_ready_in_reset_valid", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_slots", {out_a, out_b, out_c, out_d}, 0);
    check("rst_mask", out_pad_mask, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Full frame, single-cycle valid
    out_ready = 1'b1;
    push(8'h10, 8'h20, 8'h30, 8'h40, 4'b0000);
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
    #1 check("full_valid", out_valid, 1);
    @(negedge clk); #1 check("full_valid_one_clk", out_valid, 0);
    @(negedge clk);

    // Short frames padded
    push(8'h05, 8'h07, PAD, PAD, 4'b1100);
    push(8'h09, PAD, PAD, PAD, 4'b1110);
    send(8'h05, 0); send(8'h07, 1); send(8'h09, 1);
    @(negedge clk);

    // Backpressure: frame held, in_ready low, then consume + accept in same clk
    out_ready = 1'b0;
    push(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    in_data = 8'h99; in_valid = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold", {out_a, out_b, out_c, out_d, out_pad_mask}, {8'h11, 8'h22, 8'h33, 8'h44, 4'b0000});
      @(negedge clk);
    end
    push(8'h99, PAD, PAD, PAD, 4'b1110);
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;

    // 12 back-to-back elements, one per clk
    for (int f = 0; f < 3; f++)
      push(8'h60 + 8'(4*f), 8'h61 + 8'(4*f), 8'h62 + 8'(4*f), 8'h63 + 8'(4*f), 4'b0000);
    c0 = cycles;
    for (int i = 0; i < 12; i++) send(8'h60 + 8'(i), 0);
    check("throughput_cycles", cycles - c0, 12);

    // Reset mid-frame discards partial data
    send(8'hE1, 0); send(8'hE2, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(8'h71, 8'h72, 8'h73, 8'h74, 4'b0000);
    send(8'h71, 0); send(8'h72, 0); send(8'h73, 0); send(8'h74, 0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
`ifdef SORT_LOADER_STATS_EN
    check("frame_count", frame_count, 1);
    check("pad_count", pad_count, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
